// File: rtl/gpr_wr_sched.sv
// GPR write-port scheduler: arbitrates writeback, multi-cycle and debug
// writes onto one registered port and tracks pending multi-cycle targets.
module gpr_wr_sched #(
   parameter int REG_NUM      = 32,
   parameter int REG_AW       = 5,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wb_valid,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              mc_valid,
   output logic              mc_ready,
   input  logic [REG_AW-1:0] mc_addr,
   input  logic [DATA_W-1:0] mc_data,
   input  logic              mc_issue_en,
   input  logic [REG_AW-1:0] mc_issue_addr,
   input  logic              dbg_valid,
   output logic              dbg_ready,
   input  logic [REG_AW-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_data,
   input  logic              rd_en_0,
   input  logic [REG_AW-1:0] rd_addr_0,
   input  logic              rd_en_1,
   input  logic [REG_AW-1:0] rd_addr_1,
   output logic              hazard,
   output logic              issue_err,
   output logic              gpr_we_n,
   output logic [REG_AW-1:0] gpr_wr_addr,
   output logic [DATA_W-1:0] gpr_wr_data
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0]         starve_cnt;
   logic               starved;
   logic [REG_NUM-1:0] pending;
   logic [REG_NUM-1:0] pending_nxt;
   logic               clr_hit;

   assign starved   = (starve_cnt == LIMIT);
   assign mc_ready  = mc_valid & ~wb_valid & ~(dbg_valid & starved);
   assign dbg_ready = dbg_valid & ~wb_valid & (~mc_valid | starved);

   always_ff @(posedge clk) begin
      if (reset) begin
         gpr_we_n    <= 1'b1;
         gpr_wr_addr <= '0;
         gpr_wr_data <= '0;
      end else if (wb_valid) begin
         gpr_we_n    <= 1'b0;
         gpr_wr_addr <= wb_addr;
         gpr_wr_data <= wb_data;
      end else if (mc_ready) begin
         gpr_we_n    <= 1'b0;
         gpr_wr_addr <= mc_addr;
         gpr_wr_data <= mc_data;
      end else if (dbg_ready) begin
         gpr_we_n    <= 1'b0;
         gpr_wr_addr <= dbg_addr;
         gpr_wr_data <= dbg_data;
      end else begin
         gpr_we_n    <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (!dbg_valid || dbg_ready) begin
         starve_cnt <= '0;
      end else if (!starved) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

   // A retiring op on the same register frees it, so a re-issue is legal.
   assign clr_hit = mc_ready & (mc_addr == mc_issue_addr);

   always_comb begin
      pending_nxt = pending;
      if (mc_ready) begin
         pending_nxt[mc_addr] = 1'b0;
      end
      if (mc_issue_en) begin
         pending_nxt[mc_issue_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending   <= '0;
         issue_err <= 1'b0;
      end else begin
         pending   <= pending_nxt;
         issue_err <= mc_issue_en & pending[mc_issue_addr] & ~clr_hit;
      end
   end

   assign hazard = (rd_en_0 & pending[rd_addr_0])
                 | (rd_en_1 & pending[rd_addr_1]);

endmodule

// File: tb/tb_gpr_wr_sched.sv
// Scoreboard bench for gpr_wr_sched: expected writes are queued at accept
// time and matched by a monitor against the register-file port.
module tb_gpr_wr_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_valid, mc_valid, dbg_valid;
   logic [4:0]  wb_addr, mc_addr, dbg_addr, mc_issue_addr;
   logic [31:0] wb_data, mc_data, dbg_data;
   logic        mc_issue_en, mc_ready, dbg_ready;
   logic        rd_en_0, rd_en_1;
   logic [4:0]  rd_addr_0, rd_addr_1;
   logic        hazard, issue_err, gpr_we_n;
   logic [4:0]  gpr_wr_addr;
   logic [31:0] gpr_wr_data;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
      int          c;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   vecs = 0;
   int   bad = 0;
   logic done = 1'b0;

   gpr_wr_sched dut (
      .clk(clk), .reset(reset),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .mc_valid(mc_valid), .mc_ready(mc_ready),
      .mc_addr(mc_addr), .mc_data(mc_data),
      .mc_issue_en(mc_issue_en), .mc_issue_addr(mc_issue_addr),
      .dbg_valid(dbg_valid), .dbg_ready(dbg_ready),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data),
      .rd_en_0(rd_en_0), .rd_addr_0(rd_addr_0),
      .rd_en_1(rd_en_1), .rd_addr_1(rd_addr_1),
      .hazard(hazard), .issue_err(issue_err),
      .gpr_we_n(gpr_we_n), .gpr_wr_addr(gpr_wr_addr),
      .gpr_wr_data(gpr_wr_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
      exp_t e;
      e.a = a;
      e.d = d;
      e.c = cyc + 1;
      q.push_back(e);
   endtask

   task automatic idle();
      wb_valid = 0; mc_valid = 0; dbg_valid = 0;
      mc_issue_en = 0; rd_en_0 = 0; rd_en_1 = 0;
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (gpr_we_n === 1'b0) begin
            if (q.size() == 0) begin
               vecs++;
               bad++;
               $display("FAIL unexp_wr: got addr %0d data %0h at %0d, expected none",
                        gpr_wr_addr, gpr_wr_data, cyc);
            end else begin
               e = q.pop_front();
               chk("wr_cyc", cyc, e.c);
               chk("wr_addr", 32'(gpr_wr_addr), 32'(e.a));
               chk("wr_data", gpr_wr_data, e.d);
            end
         end
      end
   endtask

   task automatic stim();
      reset = 1;
      wb_valid = 1; mc_valid = 1; dbg_valid = 1; mc_issue_en = 1;
      wb_addr = 5'd1; mc_addr = 5'd2; dbg_addr = 5'd6;
      wb_data = 32'h1; mc_data = 32'h2; dbg_data = 32'h6;
      mc_issue_addr = 5'd0;
      rd_en_0 = 1; rd_addr_0 = 5'd0; rd_en_1 = 0; rd_addr_1 = 5'd0;
      tick();
      tick();
      #2;
      chk("rst_we_n", 32'(gpr_we_n), 1);
      chk("rst_addr", 32'(gpr_wr_addr), 0);
      chk("rst_data", gpr_wr_data, 0);
      idle();
      rd_en_0 = 1;
      reset = 0;
      tick();
      #2;
      chk("post_rst_we_n", 32'(gpr_we_n), 1);
      chk("post_rst_hazard", 32'(hazard), 0);
      chk("post_rst_err", 32'(issue_err), 0);
      idle();

      // priority
      wb_valid = 1; mc_valid = 1; dbg_valid = 1;
      wb_addr = 5'd3; wb_data = 32'h11;
      mc_addr = 5'd9; mc_data = 32'h99;
      dbg_addr = 5'd4; dbg_data = 32'h44;
      #2;
      chk("prio_mc_rdy", 32'(mc_ready), 0);
      chk("prio_dbg_rdy", 32'(dbg_ready), 0);
      expect_wr(5'd3, 32'h11);
      tick();
      wb_valid = 0;
      #2;
      chk("mc_over_dbg_mc", 32'(mc_ready), 1);
      chk("mc_over_dbg_dbg", 32'(dbg_ready), 0);
      expect_wr(5'd9, 32'h99);
      tick();
      mc_valid = 0;
      #2;
      chk("dbg_only_rdy", 32'(dbg_ready), 1);
      expect_wr(5'd4, 32'h44);
      tick();
      idle();
      tick();

      // starvation
      mc_valid = 1; mc_addr = 5'd10; mc_data = 32'hAA;
      dbg_valid = 1; dbg_addr = 5'd12; dbg_data = 32'hCC;
      for (int i = 0; i < 9; i++) begin
         #2;
         if (i < 8) begin
            chk("starve_mc_rdy", 32'(mc_ready), 1);
            chk("starve_dbg_rdy", 32'(dbg_ready), 0);
            expect_wr(5'd10, 32'hAA);
         end else begin
            chk("starved_mc_rdy", 32'(mc_ready), 0);
            chk("starved_dbg_rdy", 32'(dbg_ready), 1);
            expect_wr(5'd12, 32'hCC);
         end
         tick();
      end
      #2;
      chk("ctr_clr_mc_rdy", 32'(mc_ready), 1);
      chk("ctr_clr_dbg_rdy", 32'(dbg_ready), 0);
      expect_wr(5'd10, 32'hAA);
      tick();
      idle();
      tick();

      // scoreboard
      mc_issue_en = 1; mc_issue_addr = 5'd7;
      tick();
      mc_issue_en = 0;
      rd_en_0 = 1; rd_addr_0 = 5'd7;
      #2;
      chk("haz_r0", 32'(hazard), 1);
      rd_en_0 = 0; rd_en_1 = 1; rd_addr_1 = 5'd7;
      #1;
      chk("haz_r1", 32'(hazard), 1);
      rd_en_1 = 0;
      #1;
      chk("haz_disabled", 32'(hazard), 0);
      rd_en_0 = 1; rd_addr_0 = 5'd8;
      #1;
      chk("haz_other_reg", 32'(hazard), 0);
      tick();
      rd_addr_0 = 5'd7;
      mc_valid = 1; mc_addr = 5'd7; mc_data = 32'h77;
      #2;
      chk("haz_hold_accept", 32'(hazard), 1);
      chk("sb_mc_rdy", 32'(mc_ready), 1);
      expect_wr(5'd7, 32'h77);
      tick();
      mc_valid = 0;
      #2;
      chk("haz_cleared", 32'(hazard), 0);
      idle();
      tick();

      // collision and issue error
      mc_issue_en = 1; mc_issue_addr = 5'd5;
      tick();
      mc_valid = 1; mc_addr = 5'd5; mc_data = 32'h55;
      #2;
      expect_wr(5'd5, 32'h55);
      tick();
      idle();
      rd_en_0 = 1; rd_addr_0 = 5'd5;
      #2;
      chk("coll_err", 32'(issue_err), 0);
      chk("coll_pending", 32'(hazard), 1);
      mc_issue_en = 1; mc_issue_addr = 5'd5;
      tick();
      mc_issue_en = 0;
      #2;
      chk("dup_err", 32'(issue_err), 1);
      chk("dup_pending", 32'(hazard), 1);
      tick();
      #2;
      chk("err_pulse_end", 32'(issue_err), 0);
      mc_valid = 1; mc_addr = 5'd5; mc_data = 32'h56;
      expect_wr(5'd5, 32'h56);
      tick();
      mc_valid = 0;
      #2;
      chk("r5_cleared", 32'(hazard), 0);
      idle();
      tick();

      // reset mid-stream
      mc_issue_en = 1; mc_issue_addr = 5'd20;
      tick();
      mc_issue_en = 0;
      mc_valid = 1; mc_addr = 5'd8; mc_data = 32'h88;
      reset = 1;
      tick();
      reset = 0;
      mc_valid = 0;
      rd_en_0 = 1; rd_addr_0 = 5'd20;
      #2;
      chk("midrst_we_n", 32'(gpr_we_n), 1);
      chk("midrst_sb", 32'(hazard), 0);
      mc_valid = 1; mc_addr = 5'd20; mc_data = 32'h20;
      expect_wr(5'd20, 32'h20);
      tick();
      idle();
      tick();

      // back-to-back
      wb_valid = 1; wb_addr = 5'd1; wb_data = 32'hB1;
      expect_wr(5'd1, 32'hB1);
      tick();
      wb_valid = 0;
      mc_valid = 1; mc_addr = 5'd2; mc_data = 32'hB2;
      expect_wr(5'd2, 32'hB2);
      tick();
      mc_valid = 0;
      dbg_valid = 1; dbg_addr = 5'd31; dbg_data = 32'hB3;
      expect_wr(5'd31, 32'hB3);
      tick();
      idle();
      tick();
      tick();
      #2;
      chk("queue_drained", q.size(), 0);
   endtask

   initial begin
      idle();
      reset = 1;
      fork
         monitor();
         stim();
      join_any
      $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
